// File: rtl/write_bus_arb_pkg.sv
// Shared types and helpers for the write bus arbiter.
//   state_e   : arbiter state encoding (IDLE, XFER, RESP)
//   idx_width : width of a requester index, clog2(n) with a floor of 1
package write_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    // A single requester still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/write_bus_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req     : request vector, one bit per requester
//   prio    : index that has first claim this round
//   any_req : at least one request present
//   sel     : first requesting index at or after prio, wrapping
module rr_pick
    import write_bus_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   prio,
    output logic               any_req,
    output logic [IDX_W-1:0]   sel
);

    logic [IDX_W-1:0] pos_idx;

    // Walk from prio upward; the first hit wins.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        pos_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos_idx = IDX_W'((32'(prio) + k) % NUM_REQ);
            if (!any_req && req[pos_idx]) begin
                any_req = 1'b1;
                sel     = pos_idx;
            end
        end
    end

endmodule

// File: rtl/write_bus_arbiter.sv
// Round-robin arbiter sharing one downstream write port (addr, data, resp
// channels) among NUM_REQ requesters, one full transaction per grant.
//   clk, rst                 : clock, synchronous active-high reset
//   req_addr_write_bus_*     : per-requester address channels (flat slices)
//   req_data_write_bus_*     : per-requester write data channels
//   req_resp_write_bus_*     : per-requester response channels
//   out_addr/data/resp_*     : shared downstream channels
//   busy                     : arbiter not idle
//   grant                    : index of current owner, valid while busy
module write_bus_arbiter
    import write_bus_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_addr_write_bus_data,
    input  logic [NUM_REQ-1:0]              req_addr_write_bus_valid,
    output logic [NUM_REQ-1:0]              req_addr_write_bus_ready,

    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_write_bus_data,
    input  logic [NUM_REQ-1:0]              req_data_write_bus_valid,
    output logic [NUM_REQ-1:0]              req_data_write_bus_ready,

    output logic [NUM_REQ*DATA_WIDTH-1:0]   req_resp_write_bus_data,
    output logic [NUM_REQ-1:0]              req_resp_write_bus_valid,
    input  logic [NUM_REQ-1:0]              req_resp_write_bus_ready,

    output logic [DATA_WIDTH-1:0]           out_addr_write_bus_data,
    output logic                            out_addr_write_bus_valid,
    input  logic                            out_addr_write_bus_ready,

    output logic [DATA_WIDTH-1:0]           out_data_write_bus_data,
    output logic                            out_data_write_bus_valid,
    input  logic                            out_data_write_bus_ready,

    input  logic [DATA_WIDTH-1:0]           out_resp_write_bus_data,
    input  logic                            out_resp_write_bus_valid,
    output logic                            out_resp_write_bus_ready,

    output logic                            busy,
    output logic [idx_width(NUM_REQ)-1:0]   grant
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    state_e           state;
    state_e           state_d;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] prio_q;
    logic             addr_done;
    logic             data_done;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    logic                  g_addr_valid;
    logic [DATA_WIDTH-1:0] g_addr_data;
    logic                  g_data_valid;
    logic [DATA_WIDTH-1:0] g_data_data;
    logic                  g_resp_ready;

    logic addr_hs;
    logic data_hs;
    logic resp_hs;
    logic xfer_done;

    // Only address valid counts as a request.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_addr_write_bus_valid),
        .prio    (prio_q),
        .any_req (pick_any),
        .sel     (pick_idx)
    );

    // Mux out the owning requester's upstream signals.
    always_comb begin
        g_addr_valid = 1'b0;
        g_addr_data  = '0;
        g_data_valid = 1'b0;
        g_data_data  = '0;
        g_resp_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                g_addr_valid = req_addr_write_bus_valid[i];
                g_addr_data  = req_addr_write_bus_data[i*DATA_WIDTH +: DATA_WIDTH];
                g_data_valid = req_data_write_bus_valid[i];
                g_data_data  = req_data_write_bus_data[i*DATA_WIDTH +: DATA_WIDTH];
                g_resp_ready = req_resp_write_bus_ready[i];
            end
        end
    end

    assign addr_hs   = (state == XFER) && g_addr_valid && !addr_done && out_addr_write_bus_ready;
    assign data_hs   = (state == XFER) && g_data_valid && !data_done && out_data_write_bus_ready;
    assign resp_hs   = (state == RESP) && out_resp_write_bus_valid && g_resp_ready;
    // Counts beats landing this cycle so addr/data may finish in either order.
    assign xfer_done = (addr_done || addr_hs) && (data_done || data_hs);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick_any)  state_d = XFER;
            XFER:    if (xfer_done) state_d = RESP;
            RESP:    if (resp_hs)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Owner, fairness pointer and per-channel completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q   <= '0;
            prio_q    <= '0;
            addr_done <= 1'b0;
            data_done <= 1'b0;
        end else begin
            if (state == IDLE && pick_any) begin
                grant_q <= pick_idx;
            end
            if (state == XFER) begin
                if (xfer_done) begin
                    addr_done <= 1'b0;
                    data_done <= 1'b0;
                end else begin
                    if (addr_hs) addr_done <= 1'b1;
                    if (data_hs) data_done <= 1'b1;
                end
            end
            if (resp_hs) begin
                prio_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            end
        end
    end

    // Output decode; only the owner is ever connected through.
    always_comb begin
        req_addr_write_bus_ready = '0;
        req_data_write_bus_ready = '0;
        req_resp_write_bus_valid = '0;
        req_resp_write_bus_data  = '0;
        out_addr_write_bus_data  = '0;
        out_addr_write_bus_valid = 1'b0;
        out_data_write_bus_data  = '0;
        out_data_write_bus_valid = 1'b0;
        out_resp_write_bus_ready = 1'b0;
        busy                     = (state != IDLE);
        grant                    = grant_q;
        case (state)
            XFER: begin
                out_addr_write_bus_valid = g_addr_valid && !addr_done;
                out_addr_write_bus_data  = g_addr_data;
                out_data_write_bus_valid = g_data_valid && !data_done;
                out_data_write_bus_data  = g_data_data;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == IDX_W'(i)) begin
                        req_addr_write_bus_ready[i] = out_addr_write_bus_ready && !addr_done;
                        req_data_write_bus_ready[i] = out_data_write_bus_ready && !data_done;
                    end
                end
            end
            RESP: begin
                out_resp_write_bus_ready = g_resp_ready;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == IDX_W'(i)) begin
                        req_resp_write_bus_valid[i] = out_resp_write_bus_valid;
                        req_resp_write_bus_data[i*DATA_WIDTH +: DATA_WIDTH] = out_resp_write_bus_data;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_write_bus_arbiter.sv
// Directed, table-driven bench for write_bus_arbiter (NUM_REQ=2, DATA_WIDTH=8).
module tb_write_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_addr_write_bus_data;
    logic [1:0]  req_addr_write_bus_valid;
    logic [1:0]  req_addr_write_bus_ready;
    logic [15:0] req_data_write_bus_data;
    logic [1:0]  req_data_write_bus_valid;
    logic [1:0]  req_data_write_bus_ready;
    logic [15:0] req_resp_write_bus_data;
    logic [1:0]  req_resp_write_bus_valid;
    logic [1:0]  req_resp_write_bus_ready;
    logic [7:0]  out_addr_write_bus_data;
    logic        out_addr_write_bus_valid;
    logic        out_addr_write_bus_ready;
    logic [7:0]  out_data_write_bus_data;
    logic        out_data_write_bus_valid;
    logic        out_data_write_bus_ready;
    logic [7:0]  out_resp_write_bus_data;
    logic        out_resp_write_bus_valid;
    logic        out_resp_write_bus_ready;
    logic        busy;
    logic [0:0]  grant;

    always #5 clk = ~clk;

    write_bus_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .req_addr_write_bus_data  (req_addr_write_bus_data),
        .req_addr_write_bus_valid (req_addr_write_bus_valid),
        .req_addr_write_bus_ready (req_addr_write_bus_ready),
        .req_data_write_bus_data  (req_data_write_bus_data),
        .req_data_write_bus_valid (req_data_write_bus_valid),
        .req_data_write_bus_ready (req_data_write_bus_ready),
        .req_resp_write_bus_data  (req_resp_write_bus_data),
        .req_resp_write_bus_valid (req_resp_write_bus_valid),
        .req_resp_write_bus_ready (req_resp_write_bus_ready),
        .out_addr_write_bus_data  (out_addr_write_bus_data),
        .out_addr_write_bus_valid (out_addr_write_bus_valid),
        .out_addr_write_bus_ready (out_addr_write_bus_ready),
        .out_data_write_bus_data  (out_data_write_bus_data),
        .out_data_write_bus_valid (out_data_write_bus_valid),
        .out_data_write_bus_ready (out_data_write_bus_ready),
        .out_resp_write_bus_data  (out_resp_write_bus_data),
        .out_resp_write_bus_valid (out_resp_write_bus_valid),
        .out_resp_write_bus_ready (out_resp_write_bus_ready),
        .busy                     (busy),
        .grant                    (grant)
    );

    typedef struct packed {
        logic        rst;
        logic [1:0]  av;
        logic [15:0] ad;
        logic [1:0]  dv;
        logic [15:0] dd;
        logic [1:0]  rr;
        logic        oar;
        logic        odr;
        logic        orv;
        logic [7:0]  ord;
    } stim_t;

    typedef struct packed {
        logic        busy;
        logic [0:0]  grant;
        logic        oav;
        logic [7:0]  oad;
        logic        odv;
        logic [7:0]  odd;
        logic        orr;
        logic [1:0]  ar;
        logic [1:0]  dr;
        logic [1:0]  rv;
        logic [15:0] rd;
    } obs_t;

    typedef struct {
        stim_t s;
        obs_t  e;
        bit    chk_grant;
        int    scen;
    } vec_t;

    vec_t vecs[$];
    int   scen;
    int   n_cmp = 0;
    int   n_err = 0;
    obs_t zero_obs = '0;

    function automatic stim_t st(input logic r, input logic [1:0] av, input logic [15:0] ad,
                                 input logic [1:0] dv, input logic [15:0] dd, input logic [1:0] rr,
                                 input logic oar, input logic odr, input logic orv,
                                 input logic [7:0] ord);
        stim_t s;
        s.rst = r;   s.av = av;   s.ad = ad;   s.dv = dv;   s.dd = dd;
        s.rr  = rr;  s.oar = oar; s.odr = odr; s.orv = orv; s.ord = ord;
        return s;
    endfunction

    function automatic obs_t ob(input logic bz, input logic g, input logic oav, input logic [7:0] oad,
                                input logic odv, input logic [7:0] odd, input logic orr,
                                input logic [1:0] ar, input logic [1:0] dr, input logic [1:0] rv,
                                input logic [15:0] rd);
        obs_t o;
        o.busy = bz;  o.grant = g;  o.oav = oav; o.oad = oad; o.odv = odv; o.odd = odd;
        o.orr  = orr; o.ar = ar;    o.dr = dr;   o.rv = rv;   o.rd = rd;
        return o;
    endfunction

    task automatic add(input stim_t s, input obs_t e);
        vec_t v;
        v.s = s; v.e = e; v.chk_grant = e.busy; v.scen = scen;
        vecs.push_back(v);
    endtask

    // Same as add, but grant is compared even while idle.
    task automatic add_g(input stim_t s, input obs_t e);
        vec_t v;
        v.s = s; v.e = e; v.chk_grant = 1'b1; v.scen = scen;
        vecs.push_back(v);
    endtask

    task automatic drive(input stim_t s);
        rst                      = s.rst;
        req_addr_write_bus_valid = s.av;
        req_addr_write_bus_data  = s.ad;
        req_data_write_bus_valid = s.dv;
        req_data_write_bus_data  = s.dd;
        req_resp_write_bus_ready = s.rr;
        out_addr_write_bus_ready = s.oar;
        out_data_write_bus_ready = s.odr;
        out_resp_write_bus_valid = s.orv;
        out_resp_write_bus_data  = s.ord;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy  = busy;
        o.grant = grant;
        o.oav   = out_addr_write_bus_valid;
        o.oad   = out_addr_write_bus_data;
        o.odv   = out_data_write_bus_valid;
        o.odd   = out_data_write_bus_data;
        o.orr   = out_resp_write_bus_ready;
        o.ar    = req_addr_write_bus_ready;
        o.dr    = req_data_write_bus_ready;
        o.rv    = req_resp_write_bus_valid;
        o.rd    = req_resp_write_bus_data;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_bits(input obs_t o);
        return {o.busy, o.oav, o.odv, o.orr, o.ar, o.dr, o.rv};
    endfunction

    initial begin
        obs_t a;
        obs_t e;

        // Scenario 1: both request, four back-to-back transactions.
        scen = 1;
        for (int t = 0; t < 4; t++) begin
            logic [7:0] r;
            logic       g;
            r = 8'hC0 + 8'(t);
            g = 1'(t % 2);
            add(st(0, 2'b11, 16'hB1A0, 2'b11, 16'hD1D0, 2'b11, 1, 1, 1, r), zero_obs);
            if (g == 1'b0) begin
                add(st(0, 2'b11, 16'hB1A0, 2'b11, 16'hD1D0, 2'b11, 1, 1, 1, r),
                    ob(1, 0, 1, 8'hA0, 1, 8'hD0, 0, 2'b01, 2'b01, 2'b00, 16'h0000));
                add(st(0, 2'b11, 16'hB1A0, 2'b11, 16'hD1D0, 2'b11, 1, 1, 1, r),
                    ob(1, 0, 0, 8'h00, 0, 8'h00, 1, 2'b00, 2'b00, 2'b01, {8'h00, r}));
            end else begin
                add(st(0, 2'b11, 16'hB1A0, 2'b11, 16'hD1D0, 2'b11, 1, 1, 1, r),
                    ob(1, 1, 1, 8'hB1, 1, 8'hD1, 0, 2'b10, 2'b10, 2'b00, 16'h0000));
                add(st(0, 2'b11, 16'hB1A0, 2'b11, 16'hD1D0, 2'b11, 1, 1, 1, r),
                    ob(1, 1, 0, 8'h00, 0, 8'h00, 1, 2'b00, 2'b00, 2'b10, {r, 8'h00}));
            end
        end
        add(st(0, 2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 0, 0, 0, 8'h00), zero_obs);

        // Scenario 2: single requester 0, response arrives on cycle 3.
        scen = 2;
        add(st(0, 2'b01, 16'h0012, 2'b01, 16'h0034, 2'b01, 1, 1, 0, 8'h00), zero_obs);
        add(st(0, 2'b01, 16'h0012, 2'b01, 16'h0034, 2'b01, 1, 1, 0, 8'h00),
            ob(1, 0, 1, 8'h12, 1, 8'h34, 0, 2'b01, 2'b01, 2'b00, 16'h0000));
        add(st(0, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b01, 1, 1, 0, 8'h00),
            ob(1, 0, 0, 8'h00, 0, 8'h00, 1, 2'b00, 2'b00, 2'b00, 16'h0000));
        add(st(0, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b01, 1, 1, 1, 8'h5A),
            ob(1, 0, 0, 8'h00, 0, 8'h00, 1, 2'b00, 2'b00, 2'b01, 16'h005A));
        add(st(0, 2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 0, 0, 0, 8'h00), zero_obs);

        // Scenario 3: requester 1, data beat lands while addr ready held low 4 cycles.
        scen = 3;
        add(st(0, 2'b10, 16'h4200, 2'b10, 16'h9900, 2'b10, 0, 1, 0, 8'h00), zero_obs);
        add(st(0, 2'b10, 16'h4200, 2'b10, 16'h9900, 2'b10, 0, 1, 0, 8'h00),
            ob(1, 1, 1, 8'h42, 1, 8'h99, 0, 2'b00, 2'b10, 2'b00, 16'h0000));
        for (int k = 0; k < 3; k++)
            add(st(0, 2'b10, 16'h4200, 2'b00, 16'h0000, 2'b10, 0, 1, 0, 8'h00),
                ob(1, 1, 1, 8'h42, 0, 8'h00, 0, 2'b00, 2'b00, 2'b00, 16'h0000));
        add(st(0, 2'b10, 16'h4200, 2'b00, 16'h0000, 2'b10, 1, 1, 0, 8'h00),
            ob(1, 1, 1, 8'h42, 0, 8'h00, 0, 2'b10, 2'b00, 2'b00, 16'h0000));
        add(st(0, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b10, 1, 1, 1, 8'hE1),
            ob(1, 1, 0, 8'h00, 0, 8'h00, 1, 2'b00, 2'b00, 2'b10, 16'hE100));
        add(st(0, 2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 0, 0, 0, 8'h00), zero_obs);

        // Scenario 4: early downstream response 0xFF during XFER is held off.
        scen = 4;
        add(st(0, 2'b01, 16'h0055, 2'b01, 16'h0066, 2'b01, 1, 0, 1, 8'hFF), zero_obs);
        add(st(0, 2'b01, 16'h0055, 2'b01, 16'h0066, 2'b01, 1, 0, 1, 8'hFF),
            ob(1, 0, 1, 8'h55, 1, 8'h66, 0, 2'b01, 2'b00, 2'b00, 16'h0000));
        add(st(0, 2'b00, 16'h0000, 2'b01, 16'h0066, 2'b01, 1, 1, 1, 8'hFF),
            ob(1, 0, 0, 8'h00, 1, 8'h66, 0, 2'b00, 2'b01, 2'b00, 16'h0000));
        add(st(0, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b01, 1, 1, 1, 8'hFF),
            ob(1, 0, 0, 8'h00, 0, 8'h00, 1, 2'b00, 2'b00, 2'b01, 16'h00FF));
        add(st(0, 2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 0, 0, 0, 8'h00), zero_obs);

        // Scenario 5: reset pulse while requester 1 is in XFER (prio was 1).
        scen = 5;
        add(st(0, 2'b10, 16'h3300, 2'b10, 16'h4400, 2'b11, 0, 0, 0, 8'h00), zero_obs);
        add(st(1, 2'b10, 16'h3300, 2'b10, 16'h4400, 2'b11, 0, 0, 0, 8'h00),
            ob(1, 1, 1, 8'h33, 1, 8'h44, 0, 2'b00, 2'b00, 2'b00, 16'h0000));
        add_g(st(0, 2'b11, 16'h3301, 2'b11, 16'h4402, 2'b11, 1, 1, 0, 8'h00), zero_obs);
        add(st(0, 2'b11, 16'h3301, 2'b11, 16'h4402, 2'b11, 1, 1, 0, 8'h00),
            ob(1, 0, 1, 8'h01, 1, 8'h02, 0, 2'b01, 2'b01, 2'b00, 16'h0000));
        add(st(0, 2'b10, 16'h3300, 2'b10, 16'h4400, 2'b11, 1, 1, 1, 8'hD0),
            ob(1, 0, 0, 8'h00, 0, 8'h00, 1, 2'b00, 2'b00, 2'b01, 16'h00D0));
        add(st(0, 2'b10, 16'h3300, 2'b10, 16'h4400, 2'b11, 1, 1, 0, 8'h00), zero_obs);
        add(st(0, 2'b10, 16'h3300, 2'b10, 16'h4400, 2'b11, 1, 1, 0, 8'h00),
            ob(1, 1, 1, 8'h33, 1, 8'h44, 0, 2'b10, 2'b10, 2'b00, 16'h0000));
        add(st(0, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b11, 1, 1, 1, 8'hD1),
            ob(1, 1, 0, 8'h00, 0, 8'h00, 1, 2'b00, 2'b00, 2'b10, 16'hD100));
        add(st(0, 2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 0, 0, 0, 8'h00), zero_obs);

        // Scenario 6: requester 1 holds resp ready low for 3 cycles in RESP.
        scen = 6;
        add(st(0, 2'b10, 16'h2100, 2'b10, 16'h3100, 2'b00, 1, 1, 1, 8'hAB), zero_obs);
        add(st(0, 2'b10, 16'h2100, 2'b10, 16'h3100, 2'b00, 1, 1, 1, 8'hAB),
            ob(1, 1, 1, 8'h21, 1, 8'h31, 0, 2'b10, 2'b10, 2'b00, 16'h0000));
        for (int k = 0; k < 3; k++)
            add(st(0, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 1, 1, 1, 8'hAB),
                ob(1, 1, 0, 8'h00, 0, 8'h00, 0, 2'b00, 2'b00, 2'b10, 16'hAB00));
        add(st(0, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b10, 1, 1, 1, 8'hAB),
            ob(1, 1, 0, 8'h00, 0, 8'h00, 1, 2'b00, 2'b00, 2'b10, 16'hAB00));
        add(st(0, 2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 0, 0, 0, 8'h00), zero_obs);

        // Hand-written: reset with every input active leaves all outputs at 0.
        drive(st(1, 2'b11, 16'hFFFF, 2'b11, 16'hFFFF, 2'b11, 1, 1, 1, 8'hFF));
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", 64'(sample()), 64'(zero_obs));
        check("reset_grant", 64'(grant), 64'd0);
        @(posedge clk);
        #1;

        // Hand-written: data valid alone never starts a transaction.
        drive(st(0, 2'b00, 16'h0000, 2'b11, 16'hAAAA, 2'b11, 1, 1, 1, 8'hFF));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("data_only_idle%0d", k), 64'(ctrl_bits(sample())), 64'd0);
            @(posedge clk);
            #1;
        end

        // Table-driven: one row per clock cycle.
        foreach (vecs[r]) begin
            drive(vecs[r].s);
            @(negedge clk);
            a = sample();
            e = vecs[r].e;
            if (!vecs[r].chk_grant) begin
                a.grant = '0;
                e.grant = '0;
            end
            if (!e.oav) begin
                a.oad = '0;
                e.oad = '0;
            end
            if (!e.odv) begin
                a.odd = '0;
                e.odd = '0;
            end
            if (e.rv == 2'b00) begin
                a.rd = '0;
                e.rd = '0;
            end
            check($sformatf("scen%0d_row%0d", vecs[r].scen, r), 64'(a), 64'(e));
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
